// File: rtl/detection_event_qualifier_if.sv
// Sample stream from the threshold comparator.
// Ports: sample_strobe (one-cycle pulse), detection_flag (result bit).
interface detection_event_qualifier_if;
  logic sample_strobe;
  logic detection_flag;

  modport master (
    output sample_strobe,
    output detection_flag
  );

  modport slave (
    input sample_strobe,
    input detection_flag
  );
endinterface

// File: rtl/detection_event_qualifier.sv
// Debounces comparator hits into object_present, counts presence events
// and raises a sticky maskable irq. Ports: clock, reset_n, enable, det
// (strobe/flag), assert_count/deassert_count, irq controls, clears,
// object_present, irq, event_count, count_overflow, fsm_state.
module detection_event_qualifier #(
  parameter int CNT_WIDTH = 16,
  parameter int DEB_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 enable,
  detection_event_qualifier_if.slave det,
  input  logic [DEB_WIDTH-1:0] assert_count,
  input  logic [DEB_WIDTH-1:0] deassert_count,
  input  logic                 irq_enable,
  input  logic                 irq_on_removal,
  input  logic                 irq_clear,
  input  logic                 count_clear,
  output logic                 object_present,
  output logic                 irq,
  output logic [CNT_WIDTH-1:0] event_count,
  output logic                 count_overflow,
  output logic [1:0]           fsm_state
);

  typedef enum logic [1:0] {
    ABSENT      = 2'd0,
    CONFIRM_ON  = 2'd1,
    PRESENT     = 2'd2,
    CONFIRM_OFF = 2'd3
  } state_t;

  localparam logic [DEB_WIDTH-1:0] ONE = DEB_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CMAX = '1;

  state_t               state_q, state_d;
  logic [DEB_WIDTH-1:0] run_q, run_d, run_inc;
  logic [DEB_WIDTH-1:0] eff_a, eff_d;
  logic                 pres_ev, rem_ev;
  logic                 present_q, irq_q, ovf_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 flag;

  // Zero thresholds behave as one.
  assign eff_a   = (assert_count == '0) ? ONE : assert_count;
  assign eff_d   = (deassert_count == '0) ? ONE : deassert_count;
  assign run_inc = run_q + ONE;
  assign flag    = det.detection_flag;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    pres_ev = 1'b0;
    rem_ev  = 1'b0;
    if (!enable) begin
      state_d = ABSENT;
      run_d   = '0;
    end else if (det.sample_strobe) begin
      unique case (state_q)
        ABSENT: begin
          run_d = '0;
          if (flag) begin
            if (eff_a == ONE) begin
              state_d = PRESENT;
              pres_ev = 1'b1;
            end else begin
              state_d = CONFIRM_ON;
              run_d   = ONE;
            end
          end
        end
        CONFIRM_ON: begin
          if (!flag) begin
            state_d = ABSENT;
            run_d   = '0;
          end else if (run_inc >= eff_a) begin
            state_d = PRESENT;
            run_d   = '0;
            pres_ev = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        PRESENT: begin
          run_d = '0;
          if (!flag) begin
            if (eff_d == ONE) begin
              state_d = ABSENT;
              rem_ev  = 1'b1;
            end else begin
              state_d = CONFIRM_OFF;
              run_d   = ONE;
            end
          end
        end
        CONFIRM_OFF: begin
          if (flag) begin
            state_d = PRESENT;
            run_d   = '0;
          end else if (run_inc >= eff_d) begin
            state_d = ABSENT;
            run_d   = '0;
            rem_ev  = 1'b1;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = ABSENT;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ABSENT;
      run_q     <= '0;
      present_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      present_q <= (state_d == PRESENT) ||
                   (state_d == CONFIRM_OFF);
    end
  end

  // A same-cycle event wins over count_clear: the clear
  // lands first and the event counts as the first one.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (count_clear) begin
      cnt_q <= pres_ev ? CNT_WIDTH'(1) : '0;
      ovf_q <= 1'b0;
    end else if (pres_ev) begin
      if (cnt_q == CMAX) begin
        ovf_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irq_q <= 1'b0;
    end else if ((pres_ev && irq_enable) ||
                 (rem_ev && irq_enable && irq_on_removal)) begin
      irq_q <= 1'b1;
    end else if (irq_clear) begin
      irq_q <= 1'b0;
    end
  end

  assign object_present = present_q;
  assign irq            = irq_q;
  assign event_count    = cnt_q;
  assign count_overflow = ovf_q;
  assign fsm_state      = state_q;

endmodule

// File: doc/detection_event_qualifier.md
# detection_event_qualifier

Debounces the per-sample `detection_flag` from the threshold comparator into a qualified `object_present` state. An object counts as present only after a programmable number of consecutive positive samples, and as absent only after a programmable number of consecutive negative samples. The block also keeps a saturating detection-event counter and raises a sticky, maskable interrupt to the SoC controller. It sits directly downstream of the threshold comparator and qualifies on the same sample strobe that fed it.

## Interface
- `CNT_WIDTH`, default 16: width of the event counter.
- `DEB_WIDTH`, default 8: width of the debounce counts and the internal run counter.

- `clock` input 1: single system clock; all logic on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `enable` input 1: block enable; low forces the FSM idle.
- `sample_strobe` input 1: one-cycle pulse marking a new comparator result (the comparator's `data_valid`, delayed one cycle).
- `detection_flag` input 1: comparator detection result; sampled only when `sample_strobe`=1.
- `assert_count` input DEB_WIDTH: consecutive positive samples required to declare presence; 0 is treated as 1.
- `deassert_count` input DEB_WIDTH: consecutive negative samples required to declare absence; 0 is treated as 1.
- `irq_enable` input 1: allows a presence event to set `irq_status`.
- `irq_on_removal` input 1: allows a removal event to also set `irq_status`.
- `irq_clear` input 1: one-cycle pulse that clears `irq_status`.
- `count_clear` input 1: one-cycle pulse that clears `event_count` and `count_overflow`.
- `object_present` output 1: qualified presence, registered.
- `irq` output 1: equals `irq_status`, a level interrupt.
- `event_count` output CNT_WIDTH: number of presence events, saturating.
- `count_overflow` output 1: sticky flag, set when an event arrives while the counter is saturated.
- `fsm_state` output 2: current state for debug (`ABSENT`=0, `CONFIRM_ON`=1, `PRESENT`=2, `CONFIRM_OFF`=3).

## Operation
- Define `effA = max(assert_count, 1)` and `effD = max(deassert_count, 1)`.
- `run_cnt` is a DEB_WIDTH counter of consecutive qualifying samples. It never wraps, because it resets before it can exceed `effA`/`effD`.
- FSM transitions advance only on cycles where `sample_strobe`=1 and `enable`=1:
  - `ABSENT`, flag=1: if `effA`=1, go to `PRESENT` (presence event); otherwise go to `CONFIRM_ON` with `run_cnt`=1.
  - `ABSENT`, flag=0: stay; `run_cnt`=0.
  - `CONFIRM_ON`, flag=1: `run_cnt`+1. When the incremented value ≥ `effA`, go to `PRESENT` (presence event) with `run_cnt`=0.
  - `CONFIRM_ON`, flag=0: go to `ABSENT` with `run_cnt`=0.
  - `PRESENT`, flag=0: mirror of the `ABSENT` rule, using `effD` and `CONFIRM_OFF`. A removal event occurs on reaching `ABSENT`.
  - `CONFIRM_OFF`, flag=1: return to `PRESENT` with `run_cnt`=0.
- `object_present` is 1 in `PRESENT` and `CONFIRM_OFF`, and 0 otherwise.
- `assert_count`/`deassert_count` are sampled live. If a threshold is lowered mid-confirm, the ≥ comparison takes effect on the next strobe.
- Presence event:
  - `event_count`+1, saturating at all-ones.
  - If `event_count` is already all-ones, set `count_overflow`.
  - If `irq_enable`=1, set `irq_status`.
- Removal event: sets `irq_status` only if `irq_enable`=1 and `irq_on_removal`=1.
- Interaction of clears with events:
  - Set beats `irq_clear` in the same cycle.
  - When `count_clear` and a presence event occur in the same cycle, `event_count`=1 and `count_overflow`=0.
- `enable`=0:
  - Synchronously forces the FSM to `ABSENT` with `run_cnt`=0 and `object_present`=0.
  - This forced exit from `PRESENT` is not a removal event.
  - `event_count`, `count_overflow` and `irq_status` are retained, and clears still work.
- `sample_strobe` with `enable`=0 is ignored.

## Timing
- Reset values (asynchronous on `reset_n`=0): state `ABSENT`, `run_cnt`=0, `object_present`=0, `irq`=0, `event_count`=0, `count_overflow`=0, `fsm_state`=0.
- All outputs are registered.
- `object_present`, `irq`, `event_count` and `fsm_state` update together, one clock after the qualifying strobe edge.
- Latency from the first positive strobe to `object_present`=1 is `effA` strobes plus one clock; with back-to-back strobes that is `effA` clocks.
- `irq` falls on the clock after `irq_clear`; the counters clear on the clock after `count_clear`.
- No back-pressure: every strobe is consumed.
- Strobes may arrive on consecutive cycles or be spaced arbitrarily. Only the strobe count matters, not elapsed cycles.
- Reset asserted mid-confirm aborts the confirm with no event. The first strobe after reset release is processed normally.

## Test plan
- **Debounce on:** `assert_count`=3, `irq_enable`=1; strobes with flag 1,1,1.
  - Expect `object_present` and `irq` to rise on the clock after the third strobe, with `event_count`=1.
- **Glitch rejection:** `assert_count`=3; flags 1,1,0,1,1.
  - Expect `object_present` to stay 0 and `fsm_state` to return to 0 after the third strobe. The fifth strobe leaves state `CONFIRM_ON` with `run_cnt`=2.
- **Removal with IRQ:**
  - Setup: `deassert_count`=2, `irq_on_removal`=1, in `PRESENT`, then `irq_clear` pulsed.
  - Stimulus: flags 0,1,0,0.
  - Expect the second strobe to return the FSM to `PRESENT`. After the fourth strobe, `object_present`=0, `irq`=1 and `event_count` unchanged.
- **Counter saturation:** `CNT_WIDTH`=4, `assert_count`=0; drive 17 presence events.
  - Expect `event_count`=15 and `count_overflow`=1.
  - Then assert `count_clear` together with the 18th event: expect `event_count`=1 and `count_overflow`=0.
- **Enable drop and clear priority:**
  - Drop `enable` in `PRESENT`: expect `object_present`=0 next clock, no `irq`, `event_count` held.
  - Assert `irq_clear` in the same cycle as a presence event: expect `irq` to stay 1.
- **Async reset mid-confirm:** assert `reset_n` low between strobes during `CONFIRM_ON`.
  - Expect all outputs to reach their reset values immediately, without waiting for a clock edge.
